snake_grid_engine: RTL and testbench



---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_grid_engine_if.sv | 36 +++
 rtl/snake_seg_ring.sv | 42 ++++
 rtl/snake_grid_engine.sv | 186 ++++++++++++++++++
 tb/tb_snake_grid_engine.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake grid engine.
// Holds the direction encoding, the FSM state type, and the direction and cell-index helpers.
// Pure declarations: there is no timing and no backpressure.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MOVE,
        ST_DEAD
    } state_t;

    // Opposite directions share the high bit and differ only in the low bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    // Row-major index of a cell in the occupancy bitmap.
    function automatic int cell_idx(input int x, input int y, input int grid_w);
        return y * grid_w + x;
    endfunction

endpackage

// File: rtl/snake_grid_engine_if.sv
// Control and status bundle between the game controller or renderer and the snake engine.
// master drives the ticks, direction, grow, restart and query cell; slave returns head, length, status and query results.
// Has no latency of its own and no backpressure: every strobe is a single-cycle pulse.
interface snake_grid_engine_if #(
    parameter int X_W     = 6,
    parameter int Y_W     = 5,
    parameter int MAX_LEN = 64
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic           step;
    logic           dir_valid;
    logic [1:0]     dir;
    logic           grow;
    logic           restart;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [LW-1:0]  length;
    logic           alive;
    logic           dead;
    logic           busy;
    logic [X_W-1:0] query_x;
    logic [Y_W-1:0] query_y;
    logic           query_hit;
    logic           query_head;

    modport master (
        output step, dir_valid, dir, grow, restart, query_x, query_y,
        input  head_x, head_y, length, alive, dead, busy, query_hit, query_head
    );

    modport slave (
        input  step, dir_valid, dir, grow, restart, query_x, query_y,
        output head_x, head_y, length, alive, dead, busy, query_hit, query_head
    );
endinterface

// File: rtl/snake_seg_ring.sv
// Ring buffer of body coordinates, with the head pushed at the write side and the tail popped at the read side.
// Push and pop take effect at the clock edge. tail_dat is a combinational peek at the oldest entry.
// There is no backpressure: the engine never pushes past DEPTH live entries. clear takes priority over push and pop.
module snake_seg_ring #(
    parameter int W     = 11,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] tail_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // When the ring is full, a push and a pop in the same cycle overwrite the slot being popped.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_dat;
    end

    assign tail_dat = mem[rd_ptr];

endmodule

// File: rtl/snake_grid_engine.sv
// Snake body engine: a coordinate ring buffer mirrored into a per-cell occupancy bitmap, with wall and self collision detection.
// A step in RUN is taken in the MOVE cycle that follows, and the result is visible after that edge. query_hit and query_head have 1-cycle latency.
// There is no backpressure: a step outside RUN is dropped, and restart overrides everything.
// Ports: clk and rst (async, active-high), plus the sg bundle (slave modport) that carries the ticks, status and cell query.
module snake_grid_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0
) (
    input  logic clk,
    input  logic rst,
    snake_grid_engine_if.slave sg
);
    localparam int NCELLS = GRID_W * GRID_H;
    localparam int IW     = $clog2(NCELLS);
    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int CW     = $clog2(INIT_LEN + 1);
    localparam int PW     = X_W + Y_W;

    state_t            state, state_n;
    logic [CW-1:0]     init_cnt;
    logic [NCELLS-1:0] bitmap;
    logic [X_W-1:0]    head_x, next_x, tail_x;
    logic [Y_W-1:0]    head_y, next_y, tail_y;
    logic [LW-1:0]     length;
    dir_t              cur_dir, pend_dir, req_dir;
    logic              grow_pend, dead_q, q_hit, q_head;
    logic              wall, body_hit, hit, growing, last_init, push, pop, q_in;
    logic [IW-1:0]     next_idx, tail_idx, init_idx, q_idx;
    logic [PW-1:0]     push_dat, tail_dat;
    int                nx_i, ny_i, init_x_i;

    assign req_dir   = dir_t'(sg.dir);
    assign last_init = (init_cnt == CW'(INIT_LEN - 1));
    assign init_x_i  = GRID_W / 2 - INIT_LEN + 1 + int'(init_cnt);
    assign init_idx  = IW'(cell_idx(init_x_i, GRID_H / 2, GRID_W));

    // Candidate head cell. Without wrap, leaving the grid is flagged as a wall hit.
    always_comb begin
        nx_i = int'(head_x);
        ny_i = int'(head_y);
        wall = 1'b0;
        case (pend_dir)
            DIR_UP:    ny_i = ny_i - 1;
            DIR_DOWN:  ny_i = ny_i + 1;
            DIR_LEFT:  nx_i = nx_i - 1;
            default:   nx_i = nx_i + 1;
        endcase
        if (nx_i < 0) begin
            if (WRAP != 0) nx_i = GRID_W - 1; else wall = 1'b1;
        end else if (nx_i >= GRID_W) begin
            if (WRAP != 0) nx_i = 0; else wall = 1'b1;
        end
        if (ny_i < 0) begin
            if (WRAP != 0) ny_i = GRID_H - 1; else wall = 1'b1;
        end else if (ny_i >= GRID_H) begin
            if (WRAP != 0) ny_i = 0; else wall = 1'b1;
        end
        next_x = wall ? '0 : X_W'(nx_i);
        next_y = wall ? '0 : Y_W'(ny_i);
    end

    assign next_idx = IW'(cell_idx(int'(next_x), int'(next_y), GRID_W));
    assign tail_x   = tail_dat[PW-1:Y_W];
    assign tail_y   = tail_dat[Y_W-1:0];
    assign tail_idx = IW'(cell_idx(int'(tail_x), int'(tail_y), GRID_W));
    assign growing  = grow_pend && (int'(length) < MAX_LEN);
    // Stepping onto the tail is legal when the tail vacates in the same move.
    assign body_hit = !wall && bitmap[next_idx] &&
                      !(next_x == tail_x && next_y == tail_y && !growing);
    assign hit      = wall || body_hit;

    assign push     = !sg.restart && ((state == ST_INIT) || (state == ST_MOVE && !hit));
    assign pop      = !sg.restart && (state == ST_MOVE) && !hit && !growing;
    assign push_dat = (state == ST_INIT) ? {X_W'(init_x_i), Y_W'(GRID_H / 2)} : {next_x, next_y};

    snake_seg_ring #(.W(PW), .DEPTH(MAX_LEN)) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clear    (sg.restart),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .tail_dat (tail_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (sg.restart) begin
            state_n = ST_INIT;
        end else begin
            case (state)
                ST_INIT: if (last_init) state_n = ST_RUN;
                ST_RUN:  if (sg.step)   state_n = ST_MOVE;
                ST_MOVE: state_n = hit ? ST_DEAD : ST_RUN;
                default: state_n = ST_DEAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            bitmap    <= '0;
            head_x    <= X_W'(GRID_W / 2);
            head_y    <= Y_W'(GRID_H / 2);
            length    <= '0;
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            dead_q    <= 1'b0;
        end else if (sg.restart) begin
            init_cnt  <= '0;
            bitmap    <= '0;
            head_x    <= X_W'(GRID_W / 2);
            head_y    <= Y_W'(GRID_H / 2);
            length    <= '0;
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            dead_q <= 1'b0;
            if (sg.dir_valid && req_dir != opposite(cur_dir)) pend_dir <= req_dir;
            if (sg.grow) grow_pend <= 1'b1;
            case (state)
                ST_INIT: begin
                    bitmap[init_idx] <= 1'b1;
                    init_cnt         <= init_cnt + CW'(1);
                    if (last_init) length <= LW'(INIT_LEN);
                end
                ST_MOVE: begin
                    cur_dir   <= pend_dir;
                    // A grow arriving during MOVE belongs to the next move.
                    grow_pend <= sg.grow;
                    if (hit) begin
                        dead_q <= 1'b1;
                    end else begin
                        // The set follows the clear, so a cell that is both vacated and entered stays occupied.
                        if (!growing) bitmap[tail_idx] <= 1'b0;
                        bitmap[next_idx] <= 1'b1;
                        head_x <= next_x;
                        head_y <= next_y;
                        length <= length + {{(LW-1){1'b0}}, growing};
                    end
                end
                default: ;
            endcase
        end
    end

    // Renderer query: out-of-grid cells must not alias onto real bitmap bits.
    assign q_in  = (int'(sg.query_x) < GRID_W) && (int'(sg.query_y) < GRID_H);
    assign q_idx = q_in ? IW'(cell_idx(int'(sg.query_x), int'(sg.query_y), GRID_W)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_hit  <= 1'b0;
            q_head <= 1'b0;
        end else begin
            q_hit  <= q_in && bitmap[q_idx];
            q_head <= q_in && (sg.query_x == head_x) && (sg.query_y == head_y);
        end
    end

    assign sg.head_x     = head_x;
    assign sg.head_y     = head_y;
    assign sg.length     = length;
    assign sg.alive      = (state == ST_RUN) || (state == ST_MOVE);
    assign sg.busy       = (state == ST_INIT) || (state == ST_MOVE);
    assign sg.dead       = dead_q;
    assign sg.query_hit  = q_hit;
    assign sg.query_head = q_head;

endmodule

// File: tb/tb_snake_grid_engine.sv
// Directed bench for three engine builds that share one stimulus: default (wall kills), WRAP=1, and MAX_LEN=4.
// The bench drives and samples on the falling edge, so each single-cycle pulse lasts exactly one rising edge.
// Expected values are hand-derived coordinates and lengths from the snake rules.
module tb_snake_grid_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t_step = 1'b0, t_dir_valid = 1'b0, t_grow = 1'b0, t_restart = 1'b0;
    logic [1:0] t_dir = 2'b11;
    logic [5:0] t_qx = '0;
    logic [4:0] t_qy = '0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    snake_grid_engine_if #(.X_W(6), .Y_W(5), .MAX_LEN(64)) if_a ();
    snake_grid_engine_if #(.X_W(6), .Y_W(5), .MAX_LEN(64)) if_w ();
    snake_grid_engine_if #(.X_W(6), .Y_W(5), .MAX_LEN(4))  if_m ();

    assign if_a.step = t_step;  assign if_a.dir_valid = t_dir_valid; assign if_a.dir = t_dir;
    assign if_a.grow = t_grow;  assign if_a.restart = t_restart;
    assign if_a.query_x = t_qx; assign if_a.query_y = t_qy;
    assign if_w.step = t_step;  assign if_w.dir_valid = t_dir_valid; assign if_w.dir = t_dir;
    assign if_w.grow = t_grow;  assign if_w.restart = t_restart;
    assign if_w.query_x = t_qx; assign if_w.query_y = t_qy;
    assign if_m.step = t_step;  assign if_m.dir_valid = t_dir_valid; assign if_m.dir = t_dir;
    assign if_m.grow = t_grow;  assign if_m.restart = t_restart;
    assign if_m.query_x = t_qx; assign if_m.query_y = t_qy;

    snake_grid_engine #(.WRAP(0))              dut_a (.clk(clk), .rst(rst), .sg(if_a));
    snake_grid_engine #(.WRAP(1))              dut_w (.clk(clk), .rst(rst), .sg(if_w));
    snake_grid_engine #(.WRAP(0), .MAX_LEN(4)) dut_m (.clk(clk), .rst(rst), .sg(if_m));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One step pulse: the RUN edge enters MOVE and the next edge commits it.
    task automatic do_step();
        t_step = 1'b1; tick();
        t_step = 1'b0; tick();
    endtask

    task automatic turn(input logic [1:0] d);
        t_dir = d; t_dir_valid = 1'b1; tick();
        t_dir_valid = 1'b0;
        do_step();
    endtask

    task automatic grow_step();
        t_grow = 1'b1; tick();
        t_grow = 1'b0;
        do_step();
    endtask

    task automatic query(input int x, input int y);
        t_qx = 6'(x); t_qy = 5'(y); tick();
    endtask

    task automatic do_restart();
        t_restart = 1'b1; tick();
        t_restart = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        // Values while reset is held
        check("rst_head_x", 32'(if_a.head_x), 20);
        check("rst_head_y", 32'(if_a.head_y), 15);
        check("rst_length", 32'(if_a.length), 0);
        check("rst_alive",  32'(if_a.alive), 0);
        check("rst_busy",   32'(if_a.busy), 1);
        check("rst_dead",   32'(if_a.dead), 0);
        check("rst_qhit",   32'(if_a.query_hit), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Initial body is (18,15) (19,15) (20,15)
        check("init_len",   32'(if_a.length), 3);
        check("init_alive", 32'(if_a.alive), 1);
        check("init_busy",  32'(if_a.busy), 0);
        check("init_hx",    32'(if_a.head_x), 20);
        query(18, 15); check("q18_hit", 32'(if_a.query_hit), 1); check("q18_head", 32'(if_a.query_head), 0);
        query(20, 15); check("q20_hit", 32'(if_a.query_hit), 1); check("q20_head", 32'(if_a.query_head), 1);
        query(17, 15); check("q17_hit", 32'(if_a.query_hit), 0);
        // (58,14) would alias onto bitmap bit 618 = (18,15) without the grid guard
        query(58, 14); check("q_oob_hit", 32'(if_a.query_hit), 0); check("q_oob_head", 32'(if_a.query_head), 0);

        // Single step right; busy is high during MOVE
        t_step = 1'b1; tick(); t_step = 1'b0;
        check("move_busy", 32'(if_a.busy), 1);
        tick();
        check("s1_hx", 32'(if_a.head_x), 21);
        check("s1_len", 32'(if_a.length), 3);
        query(18, 15); check("s1_tail_gone", 32'(if_a.query_hit), 0);

        // Reversal to the left is dropped
        turn(2'b10);
        check("rev_hx", 32'(if_a.head_x), 22);
        check("rev_hy", 32'(if_a.head_y), 15);

        // Growth: the body is now (20..23,15)
        grow_step();
        check("g1_len", 32'(if_a.length), 4);
        check("g1_hx", 32'(if_a.head_x), 23);
        query(20, 15); check("g1_q20", 32'(if_a.query_hit), 1);
        // A second grow: the MAX_LEN=4 build consumes it without growing
        grow_step();
        check("g2_len_a", 32'(if_a.length), 5);
        check("g2_len_m", 32'(if_m.length), 4);
        query(20, 15);
        check("g2_q20_a", 32'(if_a.query_hit), 1);
        check("g2_q20_m", 32'(if_m.query_hit), 0);
        do_step();
        check("g3_len_a", 32'(if_a.length), 5);
        check("g3_len_m", 32'(if_m.length), 4);
        check("g3_hx", 32'(if_a.head_x), 25);

        // Walk to the right edge, x = 39
        for (int i = 0; i < 14; i++) do_step();
        check("edge_hx", 32'(if_a.head_x), 39);
        check("edge_alive", 32'(if_a.alive), 1);
        do_step();
        check("wall_dead", 32'(if_a.dead), 1);
        check("wall_alive", 32'(if_a.alive), 0);
        check("wall_hx", 32'(if_a.head_x), 39);
        check("wall_hy", 32'(if_a.head_y), 15);
        check("wrap_hx", 32'(if_w.head_x), 0);
        check("wrap_alive", 32'(if_w.alive), 1);
        check("wrap_dead", 32'(if_w.dead), 0);
        tick();
        check("dead_pulse", 32'(if_a.dead), 0);
        do_step();
        check("dead_ign_hx", 32'(if_a.head_x), 39);
        check("dead_busy", 32'(if_a.busy), 0);
        check("wrap_hx2", 32'(if_w.head_x), 1);

        // Up then left before one step: left is opposite of right and dropped, so up stands
        t_dir = 2'b00; t_dir_valid = 1'b1; tick();
        t_dir = 2'b10; tick();
        t_dir_valid = 1'b0;
        for (int i = 0; i < 15; i++) do_step();
        check("up_hx", 32'(if_w.head_x), 1);
        check("up_hy", 32'(if_w.head_y), 0);
        do_step();
        check("upwrap_hy", 32'(if_w.head_y), 29);
        check("upwrap_alive", 32'(if_w.alive), 1);
        check("dead_hold_hx", 32'(if_a.head_x), 39);

        // Restart
        do_restart();
        check("rs_busy", 32'(if_a.busy), 1);
        check("rs_len0", 32'(if_a.length), 0);
        repeat (3) tick();
        check("rs_len", 32'(if_a.length), 3);
        check("rs_alive", 32'(if_a.alive), 1);
        check("rs_w_hy", 32'(if_w.head_y), 15);
        query(39, 15); check("rs_clear", 32'(if_a.query_hit), 0);

        // Length 4: a 2x2 loop always steps into the vacating tail
        grow_step();
        turn(2'b00); turn(2'b10); turn(2'b01); turn(2'b11);
        check("loop4_alive", 32'(if_a.alive), 1);
        check("loop4_hx", 32'(if_a.head_x), 21);
        check("loop4_hy", 32'(if_a.head_y), 15);
        check("loop4_len", 32'(if_a.length), 4);
        query(20, 15); check("loop4_q2015", 32'(if_a.query_hit), 1);
        query(22, 15); check("loop4_q2215", 32'(if_a.query_hit), 0);

        // Length 5: grow, then up, left, down; down hits (21,15), which is not the tail
        grow_step();
        turn(2'b00); turn(2'b10);
        check("loop5_alive_pre", 32'(if_a.alive), 1);
        turn(2'b01);
        check("loop5_dead", 32'(if_a.dead), 1);
        check("loop5_hx", 32'(if_a.head_x), 21);
        check("loop5_hy", 32'(if_a.head_y), 14);
        check("loop5_m_alive", 32'(if_m.alive), 1);
        check("loop5_m_hy", 32'(if_m.head_y), 15);

        // Restart asserted in the MOVE cycle wins over the move
        do_restart();
        repeat (3) tick();
        t_step = 1'b1; tick(); t_step = 1'b0;
        do_restart();
        check("rm_busy", 32'(if_a.busy), 1);
        check("rm_len", 32'(if_a.length), 0);
        repeat (3) tick();
        check("rm_hx", 32'(if_a.head_x), 20);
        check("rm_len3", 32'(if_a.length), 3);
        query(21, 15); check("rm_q21", 32'(if_a.query_hit), 0);
        query(18, 15); check("rm_q18", 32'(if_a.query_hit), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
